// File: rtl/bitmask_popcount_enumerator_pkg.sv
// Shared types and constants for the same-popcount mask enumerator.
// Constants are plain ints; each module casts them to its own word width.
package bitmask_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    localparam int ZERO = 0;
    localparam int ONE  = 1;
    localparam int TWO  = 2;

endpackage

// File: rtl/bitmask_popcount_enumerator_next.sv
// Combinational lexicographic successor of x with the same popcount.
// On overflow past the top of the word it wraps to the smallest such mask.
module bitmask_next_same_popcount
    import bitmask_pkg::*;
#(
    parameter int WORD_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0] x,
    output logic [WORD_WIDTH-1:0] y
);

    localparam logic [WORD_WIDTH-1:0] ZERO_W = WORD_WIDTH'(ZERO);
    localparam logic [WORD_WIDTH-1:0] ONE_W  = WORD_WIDTH'(ONE);

    logic [WORD_WIDTH-1:0] lowest;
    logic [WORD_WIDTH:0]   sum;
    logic                  carry;
    logic [WORD_WIDTH-1:0] ripple;
    logic [WORD_WIDTH-1:0] changed;
    logic [WORD_WIDTH-1:0] fill;
    int                    n_changed;
    int                    shamt;

    always_comb begin
        lowest    = x & (~x + ONE_W);
        sum       = {1'b0, x} + {1'b0, lowest};
        carry     = sum[WORD_WIDTH];
        ripple    = sum[WORD_WIDTH-1:0];
        changed   = x ^ ripple;
        n_changed = ZERO;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            n_changed = n_changed + int'(changed[i]);
        end
        // A carry out means we ran off the top: refill all pop(x) ones at the bottom.
        shamt = n_changed + (carry ? TWO : ZERO) - TWO;
        // shamt == WORD_WIDTH only for all-ones; the shift then yields 0 and -1 gives all ones.
        fill  = (ONE_W << shamt) - ONE_W;
        if (x == ZERO_W) begin
            y = ZERO_W;
        end else begin
            y = ripple | fill;
        end
    end

endmodule

// File: rtl/bitmask_popcount_enumerator.sv
// Walks every mask with the seed's popcount, starting at the seed, one per output handshake.
// The run ends on the mask whose successor is the seed; out_last flags it.
module bitmask_popcount_enumerator
    import bitmask_pkg::*;
#(
    parameter int WORD_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   seed_valid,
    output logic                   seed_ready,
    input  logic [WORD_WIDTH-1:0]  seed_word,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_WIDTH-1:0]  out_word,
    output logic                   out_last,
    output logic [COUNT_WIDTH-1:0] out_index,
    output logic                   busy
);

    state_e                 state_q, state_d;
    logic [WORD_WIDTH-1:0]  seed_q, seed_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d;
    logic [COUNT_WIDTH-1:0] index_q, index_d;
    logic [WORD_WIDTH-1:0]  next_word;
    logic                   last;

    bitmask_next_same_popcount #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_next (
        .x(word_q),
        .y(next_word)
    );

    // Gated by state so the cleared registers (0 -> 0) do not flag last in IDLE.
    assign last = (state_q == EMIT) && (next_word == seed_q);

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        word_d  = word_q;
        index_d = index_q;
        case (state_q)
            IDLE: begin
                if (seed_valid) begin
                    state_d = EMIT;
                    seed_d  = seed_word;
                    word_d  = seed_word;
                    index_d = '0;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        word_d  = next_word;
                        index_d = index_q + COUNT_WIDTH'(ONE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= IDLE;
            seed_q  <= '0;
            word_q  <= '0;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            word_q  <= word_d;
            index_q <= index_d;
        end
    end

    assign seed_ready = (state_q == IDLE);
    assign out_valid  = (state_q == EMIT);
    assign busy       = (state_q != IDLE);
    assign out_word   = word_q;
    assign out_last   = last;
    assign out_index  = index_q;

endmodule
